// File: rtl/sign_compressor_pkg.sv
// Shared constants and FIFO entry type for the sign compressor.
// Build option: SIGN_COMPRESS_SAT_EN selects saturation on overflow.
package sign_compressor_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;

  localparam logic [HALF_W-1:0] SAT_POS = 16'h7FFF;
  localparam logic [HALF_W-1:0] SAT_NEG = 16'h8000;

  typedef struct packed {
    logic [HALF_W-1:0] data;
    logic              ovf;
  } entry_t;

endpackage

// File: rtl/sign_narrow.sv
// Combinational 32->16 signed narrowing with overflow flag.
// SIGN_COMPRESS_SAT_EN: saturate on overflow, else truncate.
module sign_narrow
  import sign_compressor_pkg::*;
(
  input  logic [WORD_W-1:0] din,
  output logic [HALF_W-1:0] dout,
  output logic              ovf
);

  logic [WORD_W-HALF_W:0] hi;
  logic                   fit;

  assign hi  = din[WORD_W-1:HALF_W-1];
  assign fit = (&hi) | ~(|hi);
  assign ovf = ~fit;

`ifdef SIGN_COMPRESS_SAT_EN
  assign dout = fit          ? din[HALF_W-1:0] :
                din[WORD_W-1] ? SAT_NEG : SAT_POS;
`else
  assign dout = din[HALF_W-1:0];
`endif

endmodule

// File: rtl/sign_compressor.sv
// Narrows signed 32-bit words to 16 bits through a 2-entry FIFO
// and counts overflowing words. Option: SIGN_COMPRESS_SAT_EN.
module sign_compressor
  import sign_compressor_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             clr_count,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        occ;
  entry_t            e0, e1, nw;
  logic [HALF_W-1:0] n_data;
  logic              n_ovf;
  logic              acc, del;

  sign_narrow u_narrow (
    .din  (in_data),
    .dout (n_data),
    .ovf  (n_ovf)
  );

  assign nw        = '{data: n_data, ovf: n_ovf};
  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign out_data  = e0.data;
  assign out_ovf   = e0.ovf;
  assign acc       = in_valid & in_ready;
  assign del       = out_valid & out_ready;

  // e0 is always the head; e1 only holds data in FULL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ <= EMPTY;
      e0  <= '0;
      e1  <= '0;
    end else begin
      unique case (occ)
        EMPTY: begin
          if (acc) begin
            e0  <= nw;
            occ <= ONE;
          end
        end
        ONE: begin
          if (acc && del) begin
            e0 <= nw;
          end else if (acc) begin
            e1  <= nw;
            occ <= FULL;
          end else if (del) begin
            occ <= EMPTY;
          end
        end
        FULL: begin
          if (del) begin
            e0  <= e1;
            occ <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_count <= '0;
    end else if (clr_count) begin
      ovf_count <= '0;
    end else if (acc && n_ovf && (ovf_count != '1)) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sign_compressor.sv
// Scoreboard bench for sign_compressor: directed vectors, queued
// expectations, negedge monitor on every delivered result.
module tb_sign_compressor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        clr_count;
  logic [3:0]  ovf_count;

  int vectors = 0;
  int miscompares = 0;
  logic [16:0] q[$];
  logic [16:0] mon_e;

`ifdef SIGN_COMPRESS_SAT_EN
  localparam logic [15:0] E_12345   = 16'h7FFF;
  localparam logic [15:0] E_8000000 = 16'h8000;
  localparam logic [15:0] E_FFF7FFF = 16'h8000;
  localparam logic [15:0] E_10000   = 16'h7FFF;
`else
  localparam logic [15:0] E_12345   = 16'h2345;
  localparam logic [15:0] E_8000000 = 16'h0000;
  localparam logic [15:0] E_FFF7FFF = 16'h7FFF;
  localparam logic [15:0] E_10000   = 16'h0000;
`endif

  sign_compressor #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .clr_count (clr_count),
    .ovf_count (ovf_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [15:0] ed,
                      input logic eo);
    int  n = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!done && n < 50) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back({ed, eo});
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: got no accept expected accept of %h", d);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", {16'h0, out_data}, {16'h0, mon_e[16:1]});
        chk("out_ovf", {31'h0, out_ovf}, {31'h0, mon_e[0]});
      end
    end
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clr_count = 1'b0;
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_data", {16'h0, out_data}, 32'h0);
    chk("rst_ovf", {31'h0, out_ovf}, 32'h0);
    chk("rst_count", {28'h0, ovf_count}, 32'h0);
    cycles(2);
    reset = 1'b0;
    chk("rst_ready", {31'h0, in_ready}, 32'h1);

    // single fitting word, one-cycle latency
    out_ready = 1'b1;
    push(32'hFFFF_8000, 16'h8000, 1'b0);
    chk("lat_valid", {31'h0, out_valid}, 32'h1);
    chk("lat_data", {16'h0, out_data}, 32'h8000);
    chk("cnt0", {28'h0, ovf_count}, 32'd0);
    cycles(1);
    chk("drained", {31'h0, out_valid}, 32'h0);

    // overflow cases and fit boundary
    push(32'h0001_2345, E_12345, 1'b1);
    chk("cnt1", {28'h0, ovf_count}, 32'd1);
    push(32'h8000_0000, E_8000000, 1'b1);
    chk("cnt2", {28'h0, ovf_count}, 32'd2);
    push(32'h0000_7FFF, 16'h7FFF, 1'b0);
    chk("cnt2b", {28'h0, ovf_count}, 32'd2);
    push(32'hFFFF_7FFF, E_FFF7FFF, 1'b1);
    chk("cnt3", {28'h0, ovf_count}, 32'd3);
    cycles(2);

    // backpressure: fill, hold, release in order
    out_ready = 1'b0;
    push(32'h1, 16'h1, 1'b0);
    push(32'h2, 16'h2, 1'b0);
    chk("full_ready", {31'h0, in_ready}, 32'h0);
    fork
      push(32'h3, 16'h3, 1'b0);
      begin
        cycles(3);
        chk("hold_data", {16'h0, out_data}, 32'h1);
        chk("hold_ready", {31'h0, in_ready}, 32'h0);
        out_ready = 1'b1;
      end
    join
    cycles(3);
    chk("bp_empty", {31'h0, out_valid}, 32'h0);

    // streaming through occupancy one, no bubbles
    out_ready = 1'b0;
    push(32'h100, 16'h100, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(i, 16'(i), 1'b0);
      chk("stream_valid", {31'h0, out_valid}, 32'h1);
    end
    cycles(2);

    // counter clear, saturation, clear-over-increment
    clr_count = 1'b1;
    push(32'h0001_0000, E_10000, 1'b1);
    clr_count = 1'b0;
    chk("clr0", {28'h0, ovf_count}, 32'd0);
    for (int i = 0; i < 20; i++) push(32'h0001_0000, E_10000, 1'b1);
    chk("sat15", {28'h0, ovf_count}, 32'd15);
    clr_count = 1'b1;
    push(32'h0001_0000, E_10000, 1'b1);
    clr_count = 1'b0;
    chk("clr_prio", {28'h0, ovf_count}, 32'd0);
    cycles(2);

    // reset while full
    out_ready = 1'b0;
    push(32'h0002_0000, E_10000, 1'b1);
    push(32'h6, 16'h6, 1'b0);
    chk("pre_rst_ready", {31'h0, in_ready}, 32'h0);
    chk("pre_rst_cnt", {28'h0, ovf_count}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_count", {28'h0, ovf_count}, 32'd0);
    chk("arst_data", {16'h0, out_data}, 32'h0);
    cycles(1);
    reset = 1'b0;
    out_ready = 1'b1;
    chk("post_rst_ready", {31'h0, in_ready}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk("no_stale", {31'h0, out_valid}, 32'h0);
    end

    for (int i = 0; i < 20 && q.size() != 0; i++) cycles(1);
    chk("sb_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
